// File: rtl/cmd_cfg_pkg.sv
// rtl/cmd_cfg_pkg.sv - opcodes, responses, FSM state type and spin-up timer widths for cmd_cfg
package cmd_cfg_pkg;

  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'hEE;

  localparam int TMR_W_SIM  = 9;
  localparam int TMR_W_FULL = 25;

  typedef enum logic [1:0] {
    IDLE,
    SPINUP,
    CAL,
    WAIT_SENT
  } cfg_state_t;

endpackage

// File: rtl/spinup_tmr.sv
// rtl/spinup_tmr.sv - free-running spin-up counter with clear, enable and all-ones flag
module spinup_tmr #(
  parameter int WIDTH = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic full
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full = &cnt_q;

endmodule

// File: rtl/cmd_cfg.sv
// rtl/cmd_cfg.sv - decodes UART commands into flight set-points and sequences spin-up/calibration
module cmd_cfg
  import cmd_cfg_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        clr_cmd_rdy,
  output logic [7:0]  resp,
  output logic        send_resp,
  input  logic        resp_sent,
  input  logic [7:0]  batt,
  input  logic        cal_done,
  output logic [15:0] d_ptch,
  output logic [15:0] d_roll,
  output logic [15:0] d_yaw,
  output logic [8:0]  thrst,
  output logic        inertial_cal,
  output logic        strt_cal,
  output logic        motors_off
);

  localparam int TMR_W = FAST_SIM ? TMR_W_SIM : TMR_W_FULL;

  cfg_state_t  state_q, state_d;
  logic [15:0] d_ptch_q, d_ptch_d;
  logic [15:0] d_roll_q, d_roll_d;
  logic [15:0] d_yaw_q, d_yaw_d;
  logic [8:0]  thrst_q, thrst_d;
  logic [7:0]  resp_q, resp_d;
  logic        send_resp_q, send_resp_d;
  logic        strt_cal_q, strt_cal_d;
  logic        inertial_cal_q, inertial_cal_d;
  logic        motors_off_q, motors_off_d;
  logic        tmr_clr, tmr_en, tmr_full;

  spinup_tmr #(.WIDTH(TMR_W)) u_spinup_tmr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .full (tmr_full)
  );

  always_comb begin
    state_d        = state_q;
    d_ptch_d       = d_ptch_q;
    d_roll_d       = d_roll_q;
    d_yaw_d        = d_yaw_q;
    thrst_d        = thrst_q;
    resp_d         = resp_q;
    send_resp_d    = 1'b0;
    strt_cal_d     = 1'b0;
    inertial_cal_d = inertial_cal_q;
    motors_off_d   = motors_off_q;
    tmr_clr        = 1'b0;
    tmr_en         = 1'b0;
    clr_cmd_rdy    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          clr_cmd_rdy = 1'b1;
          // Every opcode except CALIBRATE answers immediately, so default to that path.
          state_d     = WAIT_SENT;
          send_resp_d = 1'b1;
          resp_d      = ACK;
          case (cmd)
            REQ_BATT:  resp_d = batt;
            SET_PTCH:  d_ptch_d = data;
            SET_ROLL:  d_roll_d = data;
            SET_YAW:   d_yaw_d = data;
            SET_THRST: thrst_d = data[8:0];
            CALIBRATE: begin
              state_d        = SPINUP;
              send_resp_d    = 1'b0;
              resp_d         = resp_q;
              motors_off_d   = 1'b0;
              inertial_cal_d = 1'b1;
              tmr_clr        = 1'b1;
            end
            EMER_LAND: begin
              d_ptch_d = '0;
              d_roll_d = '0;
              d_yaw_d  = '0;
              thrst_d  = '0;
            end
            MTRS_OFF:  motors_off_d = 1'b1;
            default:   resp_d = NACK;
          endcase
        end
      end
      SPINUP: begin
        tmr_en = 1'b1;
        if (tmr_full) begin
          state_d    = CAL;
          strt_cal_d = 1'b1;
        end
      end
      CAL: begin
        if (cal_done) begin
          state_d        = WAIT_SENT;
          inertial_cal_d = 1'b0;
          resp_d         = ACK;
          send_resp_d    = 1'b1;
        end
      end
      WAIT_SENT: begin
        if (resp_sent) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      d_ptch_q       <= '0;
      d_roll_q       <= '0;
      d_yaw_q        <= '0;
      thrst_q        <= '0;
      resp_q         <= 8'h00;
      send_resp_q    <= 1'b0;
      strt_cal_q     <= 1'b0;
      inertial_cal_q <= 1'b0;
      motors_off_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      d_ptch_q       <= d_ptch_d;
      d_roll_q       <= d_roll_d;
      d_yaw_q        <= d_yaw_d;
      thrst_q        <= thrst_d;
      resp_q         <= resp_d;
      send_resp_q    <= send_resp_d;
      strt_cal_q     <= strt_cal_d;
      inertial_cal_q <= inertial_cal_d;
      motors_off_q   <= motors_off_d;
    end
  end

  assign d_ptch       = d_ptch_q;
  assign d_roll       = d_roll_q;
  assign d_yaw        = d_yaw_q;
  assign thrst        = thrst_q;
  assign resp         = resp_q;
  assign send_resp    = send_resp_q;
  assign strt_cal     = strt_cal_q;
  assign inertial_cal = inertial_cal_q;
  assign motors_off   = motors_off_q;

endmodule

// File: tb/tb_cmd_cfg.sv
// tb/tb_cmd_cfg.sv - scoreboard bench for cmd_cfg with randomized commands and a behavioural model
module tb_cmd_cfg;

  logic        clk;
  logic        rst_n;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic [7:0]  batt;
  logic        cal_done;
  logic [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0]  thrst;
  logic        inertial_cal, strt_cal, motors_off;

  cmd_cfg #(.FAST_SIM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent),
    .batt(batt), .cal_done(cal_done), .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
    .thrst(thrst), .inertial_cal(inertial_cal), .strt_cal(strt_cal), .motors_off(motors_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp = 8'h00;
  logic prev_send = 1'b0;

  logic [15:0] m_ptch, m_roll, m_yaw;
  logic [8:0]  m_thrst;
  logic        m_moff;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every send_resp pulse consumes one expected response.
  always @(negedge clk) begin
    if (rst_n && send_resp) begin
      check("send_resp_single_pulse", {63'd0, prev_send}, 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_send_resp: got resp %0h expected no response", resp);
      end else begin
        last_exp = exp_q.pop_front();
        check("resp", {56'd0, resp}, {56'd0, last_exp});
      end
    end
    prev_send = rst_n && send_resp;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ptch = '0; m_roll = '0; m_yaw = '0; m_thrst = '0; m_moff = 1'b1;
  endtask

  task automatic model_apply(input logic [7:0] c, input logic [15:0] d);
    case (c)
      8'h01: exp_q.push_back(batt);
      8'h02: begin m_ptch = d; exp_q.push_back(8'hA5); end
      8'h03: begin m_roll = d; exp_q.push_back(8'hA5); end
      8'h04: begin m_yaw = d; exp_q.push_back(8'hA5); end
      8'h05: begin m_thrst = d[8:0]; exp_q.push_back(8'hA5); end
      8'h06: m_moff = 1'b0;
      8'h07: begin m_ptch = '0; m_roll = '0; m_yaw = '0; m_thrst = '0; exp_q.push_back(8'hA5); end
      8'h08: begin m_moff = 1'b1; exp_q.push_back(8'hA5); end
      default: exp_q.push_back(8'hEE);
    endcase
  endtask

  task automatic check_regs(input string name);
    check(name, {7'd0, d_ptch, d_roll, d_yaw, thrst}, {7'd0, m_ptch, m_roll, m_yaw, m_thrst});
    check("motors_off", {63'd0, motors_off}, {63'd0, m_moff});
  endtask

  // Called from an IDLE cycle; returns one cycle after the command is consumed.
  task automatic issue(input logic [7:0] c, input logic [15:0] d);
    cmd_rdy = 1'b1; cmd = c; data = d;
    @(negedge clk);
    check("clr_cmd_rdy", {63'd0, clr_cmd_rdy}, 64'd1);
    model_apply(c, d);
    tick();
    cmd_rdy = 1'b0;
    check_regs("setpoints");
  endtask

  task automatic finish_resp(input int delay);
    int k;
    k = 0;
    while (send_resp !== 1'b1 && k < 20) begin tick(); k++; end
    check("send_resp_arrives", {63'd0, send_resp}, 64'd1);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("resp_held", {56'd0, resp}, {56'd0, last_exp});
    end
    resp_sent = 1'b1;
    tick();
    resp_sent = 1'b0;
  endtask

  task automatic wait_strt_cal(output int k);
    k = 0;
    while (strt_cal !== 1'b1 && k < 600) begin tick(); k++; end
  endtask

  initial begin
    int k, clr_hits, send_hits, resp_bad, strt_hits, ical_hits;
    logic [7:0] op;
    rst_n = 1'b0; cmd_rdy = 1'b0; cmd = '0; data = '0; resp_sent = 1'b0;
    batt = 8'h00; cal_done = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;

    clr_hits = 0; send_hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clr_hits += int'(clr_cmd_rdy);
      send_hits += int'(send_resp);
    end
    tick();
    check("idle_clr_cmd_rdy", clr_hits, 0);
    check("idle_send_resp", send_hits, 0);
    check_regs("reset_setpoints");
    check("reset_inertial_cal", {63'd0, inertial_cal}, 64'd0);
    check("reset_resp", {56'd0, resp}, 64'd0);
    check("reset_strt_cal", {63'd0, strt_cal}, 64'd0);

    issue(8'h02, 16'hFF38);
    finish_resp(2);
    issue(8'h05, 16'hFFFF);
    check("thrst_9bit", {55'd0, thrst}, 64'h1FF);
    finish_resp(0);
    issue(8'h07, 16'h1234);
    finish_resp(1);

    batt = 8'h7C;
    issue(8'h01, 16'h0000);
    batt = 8'h11;
    cmd_rdy = 1'b1; cmd = 8'h03; data = 16'h1234;
    clr_hits = 0; resp_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      clr_hits += int'(clr_cmd_rdy);
      resp_bad += int'(resp !== 8'h7C);
    end
    check("clr_while_busy", clr_hits, 0);
    check("batt_resp_held", resp_bad, 0);
    @(posedge clk); #1;
    resp_sent = 1'b1;
    tick();
    resp_sent = 1'b0;
    @(negedge clk);
    check("pending_cmd_taken", {63'd0, clr_cmd_rdy}, 64'd1);
    model_apply(8'h03, 16'h1234);
    tick();
    cmd_rdy = 1'b0;
    check_regs("pending_setpoints");
    finish_resp(1);

    issue(8'h06, 16'h0000);
    check("cal_inertial_on", {63'd0, inertial_cal}, 64'd1);
    wait_strt_cal(k);
    check("spinup_len", k, 512);
    tick();
    check("strt_cal_single", {63'd0, strt_cal}, 64'd0);
    repeat (18) tick();
    check("cal_inertial_hold", {63'd0, inertial_cal}, 64'd1);
    tick();
    cal_done = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    cal_done = 1'b0;
    check("cal_inertial_off", {63'd0, inertial_cal}, 64'd0);
    finish_resp(2);
    check_regs("post_cal");

    issue(8'h06, 16'h0000);
    cal_done = 1'b1;
    wait_strt_cal(k);
    check("spinup_len2", k, 512);
    exp_q.push_back(8'hA5);
    tick();
    cal_done = 1'b0;
    check("cal_same_cycle", {63'd0, inertial_cal}, 64'd0);
    finish_resp(0);

    issue(8'h3F, 16'h5555);
    finish_resp(1);

    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 7));
      case (k)
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        3: op = 8'h04;
        4: op = 8'h05;
        5: op = 8'h07;
        6: op = 8'h08;
        default: op = 8'($urandom_range(9, 255));
      endcase
      batt = 8'($urandom);
      issue(op, 16'($urandom));
      finish_resp(int'($urandom_range(0, 3)));
    end

    issue(8'h06, 16'h0000);
    repeat (100) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    model_reset();
    check_regs("reset_mid_spinup");
    check("reset_mid_inertial", {63'd0, inertial_cal}, 64'd0);
    strt_hits = 0; ical_hits = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      strt_hits += int'(strt_cal);
      ical_hits += int'(inertial_cal);
    end
    check("no_strt_cal_after_reset", strt_hits, 0);
    check("no_inertial_after_reset", ical_hits, 0);
    tick();

    issue(8'h04, 16'h8001);
    finish_resp(1);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
